// File: rtl/acs_array.sv
// rtl/acs_array.sv - parallel add-compare-select array for a rate-1/2 Viterbi decoder
//
// Purpose:
//   Updates all NS = 2^(K-1) path metrics in parallel for each received symbol.
//   For every state it emits one survivor decision bit, reports the best state and
//   renormalises the metrics so that they never wrap.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       (re)initialise metrics and enter RUN
//   sym_valid   sym_in carries a symbol this cycle
//   sym_in      {c0 sample, c1 sample}, SOFT_W bits each, 0 = strong 0
//   ready       high while in RUN (symbols accepted)
//   dec_valid   one-cycle pulse per processed symbol
//   dec_bits    bit s = 1 when state s selected predecessor p1
//   best_state  lowest-index state holding the minimum new metric
//   pm_out      registered metrics, state s at [s*PM_W +: PM_W]
//   norm_event  pulse: this update subtracted 2^(PM_W-1) from every metric
module acs_array #(
  parameter int             K       = 3,
  parameter logic [K-1:0]   G0      = 3'b111,
  parameter logic [K-1:0]   G1      = 3'b101,
  parameter int             SOFT_W  = 1,
  parameter int             PM_W    = 7,
  parameter int             INIT_PM = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sym_valid,
  input  logic [2*SOFT_W-1:0]       sym_in,
  output logic                      ready,
  output logic                      dec_valid,
  output logic [(1<<(K-1))-1:0]     dec_bits,
  output logic [K-2:0]              best_state,
  output logic [(1<<(K-1))*PM_W-1:0] pm_out,
  output logic                      norm_event
);

  localparam int NS = 1 << (K-1);
  localparam logic [PM_W-1:0] INIT_V = PM_W'(INIT_PM);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [SOFT_W-1:0]    s0, s1;
  logic [PM_W-1:0]      new_pm [NS];
  logic [NS-1:0]        dec_new;
  logic [PM_W-1:0]      min_v;
  logic [K-2:0]         best_d;
  logic [NS*PM_W-1:0]   next_vec;
  logic [NS*PM_W-1:0]   init_vec;
  logic                 upd;

  assign s0 = sym_in[2*SOFT_W-1:SOFT_W];
  assign s1 = sym_in[SOFT_W-1:0];

  // Start wins over a coincident symbol; symbols outside RUN are dropped.
  assign upd = (state_q == RUN) && sym_valid && !start;

  // One ACS butterfly half per destination state. The expected code bits of every
  // branch are elaboration-time constants, so only the sample/inverted-sample mux
  // and the adders remain in hardware.
  for (genvar n = 0; n < NS; n++) begin : g_state
    logic [PM_W-1:0] cand [2];

    for (genvar j = 0; j < 2; j++) begin : g_pred
      localparam int P  = (2*n + j) % NS;   // predecessor {ns[K-3:0], j}
      localparam int U  = n / (NS/2);       // input bit that leads into ns
      localparam int RI = U*NS + P;         // encoder register {u, p}
      localparam logic [K-1:0] R = RI[K-1:0];
      localparam logic EXP0 = ^(R & G0);
      localparam logic EXP1 = ^(R & G1);

      logic [SOFT_W:0] bm;
      logic [PM_W:0]   sum;

      // Distance to an expected 1 is (2^SOFT_W-1)-sample, i.e. the bitwise inverse.
      assign bm  = {1'b0, (EXP0 ? ~s0 : s0)} + {1'b0, (EXP1 ? ~s1 : s1)};
      assign sum = {1'b0, pm_out[P*PM_W +: PM_W]} + {{(PM_W-SOFT_W){1'b0}}, bm};
      assign cand[j] = sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
    end

    // Strict compare: a tie keeps predecessor p0.
    assign dec_new[n] = (cand[1] < cand[0]);
    assign new_pm[n]  = dec_new[n] ? cand[1] : cand[0];
  end

  // Minimum search, lowest index kept on ties.
  always_comb begin
    min_v  = new_pm[0];
    best_d = '0;
    for (int n = 1; n < NS; n++) begin
      if (new_pm[n] < min_v) begin
        min_v  = new_pm[n];
        best_d = n[K-2:0];
      end
    end
  end

  // Every metric >= 2^(PM_W-1) exactly when the minimum has its MSB set; since all
  // metrics are below 2^PM_W, subtracting half the range is just clearing the MSB.
  always_comb begin
    next_vec = '0;
    for (int n = 0; n < NS; n++) begin
      next_vec[n*PM_W +: PM_W] = min_v[PM_W-1] ? {1'b0, new_pm[n][PM_W-2:0]} : new_pm[n];
    end
  end

  always_comb begin
    init_vec = {NS{INIT_V}};
    init_vec[PM_W-1:0] = '0;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        ready = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pm_out     <= '0;
      dec_bits   <= '0;
      best_state <= '0;
      dec_valid  <= 1'b0;
      norm_event <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_valid  <= 1'b0;
      norm_event <= 1'b0;
      if (start) begin
        pm_out     <= init_vec;
        dec_bits   <= '0;
        best_state <= '0;
      end else if (upd) begin
        pm_out     <= next_vec;
        dec_bits   <= dec_new;
        best_state <= best_d;
        dec_valid  <= 1'b1;
        norm_event <= min_v[PM_W-1];
      end
    end
  end

endmodule
